// File: rtl/cgram_port_ctrl_if.sv
// CPU-side register bus for the palette CGRAM sequencer.
// The master drives the $2121/$2122/$213B strobes and write data.
// The slave returns the $213B read byte and the prefetch busy flag.
interface cgram_port_ctrl_if;
    logic       cpu_addr_wr;
    logic       cpu_data_wr;
    logic       cpu_data_rd;
    logic [7:0] cpu_din;
    logic       open_bus_b7;
    logic [7:0] cpu_dout;
    logic       busy;

    modport master (
        output cpu_addr_wr,
        output cpu_data_wr,
        output cpu_data_rd,
        output cpu_din,
        output open_bus_b7,
        input  cpu_dout,
        input  busy
    );

    modport slave (
        input  cpu_addr_wr,
        input  cpu_data_wr,
        input  cpu_data_rd,
        input  cpu_din,
        input  open_bus_b7,
        output cpu_dout,
        output busy
    );
endinterface

// File: rtl/cgram_port_ctrl.sv
// CPU-side sequencer for the 256x15 palette CGRAM.
// Port A carries the $2122 write pairs and a read prefetch that keeps a word
// ready for $213B. Port B is a read-only passthrough for the renderer.
module cgram_port_ctrl #(
    parameter int RAM_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    cgram_port_ctrl_if.slave     cpu,
    output logic [7:0]           ram_addr_a,
    output logic [14:0]          ram_data_a,
    output logic                 ram_wren_a,
    input  logic [14:0]          ram_q_a,
    input  logic [7:0]           render_addr,
    output logic [14:0]          render_data,
    output logic [7:0]           ram_addr_b,
    output logic [14:0]          ram_data_b,
    output logic                 ram_wren_b,
    input  logic [14:0]          ram_q_b
);

    // Counter must hold RAM_LAT itself; RAM_LAT is at least 1.
    localparam int CW = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  wait_cnt;
    logic [CW-1:0]  wait_cnt_next;

    logic [7:0]     word_addr;
    logic           flip;
    logic [7:0]     lo_latch;
    logic [14:0]    rbuf;
    logic [7:0]     dout_q;
    logic [7:0]     wr_addr;

    logic           addr_wr_go;
    logic           data_wr_go;
    logic           data_rd_go;
    logic           restart;
    logic           capture;
    logic           busy_c;

    // Resolve coinciding strobes: $2121 beats $2122 beats $213B, losers vanish.
    always_comb begin
        addr_wr_go = cpu.cpu_addr_wr;
        data_wr_go = cpu.cpu_data_wr & ~cpu.cpu_addr_wr;
        data_rd_go = cpu.cpu_data_rd & ~cpu.cpu_addr_wr & ~cpu.cpu_data_wr;
        restart    = addr_wr_go | ((data_wr_go | data_rd_go) & flip);
    end

    // Prefetch state register; reset starts a fetch of word 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ISSUE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next state: a write cycle holds the FSM in ISSUE so it re-issues afterwards.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        if (restart) begin
            state_next = ISSUE;
        end else if (ram_wren_a && state != IDLE) begin
            state_next = ISSUE;
        end else begin
            case (state)
                ISSUE: begin
                    state_next    = WAIT;
                    wait_cnt_next = CW'(RAM_LAT);
                end
                WAIT: begin
                    if (wait_cnt == CW'(1)) begin
                        state_next = IDLE;
                    end else begin
                        wait_cnt_next = wait_cnt - CW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: busy flag, capture strobe and the port A address mux.
    always_comb begin
        busy_c     = (state != IDLE);
        capture    = (state == WAIT) && (wait_cnt == CW'(1)) && !restart && !ram_wren_a;
        ram_addr_a = ram_wren_a ? wr_addr : word_addr;
    end

    // CPU register datapath: address, flip flag, latches, read buffer and write issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_addr  <= 8'h00;
            flip       <= 1'b0;
            lo_latch   <= 8'h00;
            rbuf       <= 15'h0000;
            dout_q     <= 8'h00;
            ram_wren_a <= 1'b0;
            wr_addr    <= 8'h00;
            ram_data_a <= 15'h0000;
        end else begin
            ram_wren_a <= 1'b0;
            if (capture) begin
                rbuf <= ram_q_a;
            end
            if (addr_wr_go) begin
                word_addr <= cpu.cpu_din;
                flip      <= 1'b0;
            end else if (data_wr_go) begin
                if (!flip) begin
                    lo_latch <= cpu.cpu_din;
                    flip     <= 1'b1;
                end else begin
                    ram_wren_a <= 1'b1;
                    wr_addr    <= word_addr;
                    ram_data_a <= {cpu.cpu_din[6:0], lo_latch};
                    word_addr  <= word_addr + 8'd1;
                    flip       <= 1'b0;
                end
            end else if (data_rd_go) begin
                if (!flip) begin
                    dout_q <= rbuf[7:0];
                    flip   <= 1'b1;
                end else begin
                    dout_q    <= {cpu.open_bus_b7, rbuf[14:8]};
                    word_addr <= word_addr + 8'd1;
                    flip      <= 1'b0;
                end
            end
        end
    end

    // Bus outputs and the renderer passthrough; port B is never written.
    always_comb begin
        cpu.cpu_dout = dout_q;
        cpu.busy     = busy_c;
        render_data  = ram_q_b;
        ram_addr_b   = render_addr;
        ram_data_b   = 15'h0000;
        ram_wren_b   = 1'b0;
    end

endmodule

// File: tb/tb_cgram_port_ctrl.sv
// Directed bench for cgram_port_ctrl with a behavioural dual-port CGRAM.
module tb_cgram_port_ctrl;

    logic        clock;
    logic        reset;
    logic [7:0]  ram_addr_a;
    logic [14:0] ram_data_a;
    logic        ram_wren_a;
    logic [14:0] ram_q_a;
    logic [7:0]  render_addr;
    logic [14:0] render_data;
    logic [7:0]  ram_addr_b;
    logic [14:0] ram_data_b;
    logic        ram_wren_b;
    logic [14:0] ram_q_b;

    logic        tbWr;
    logic [7:0]  tbAddr;
    logic [14:0] tbData;
    logic [14:0] mem [256];

    int          compareCount;
    int          mismatchCount;
    int          wrenCount;
    logic [7:0]  lastWrAddr;
    logic [14:0] lastWrData;

    cgram_port_ctrl_if bus ();

    cgram_port_ctrl #(.RAM_LAT(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu         (bus.slave),
        .ram_addr_a  (ram_addr_a),
        .ram_data_a  (ram_data_a),
        .ram_wren_a  (ram_wren_a),
        .ram_q_a     (ram_q_a),
        .render_addr (render_addr),
        .render_data (render_data),
        .ram_addr_b  (ram_addr_b),
        .ram_data_b  (ram_data_b),
        .ram_wren_b  (ram_wren_b),
        .ram_q_b     (ram_q_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // CGRAM model: one-cycle registered reads on both ports, bench preload port.
    always @(posedge clock) begin
        if (tbWr) mem[tbAddr] <= tbData;
        else if (ram_wren_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_wren_b) mem[ram_addr_b] <= ram_data_b;
        ram_q_a <= mem[ram_addr_a];
        ram_q_b <= mem[ram_addr_b];
    end

    // Record every port A write pulse away from the active edge.
    always @(negedge clock) begin
        if (ram_wren_a === 1'b1) begin
            wrenCount  <= wrenCount + 1;
            lastWrAddr <= ram_addr_a;
            lastWrData <= ram_data_a;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
        compareCount++;
        if (got !== want) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // Drive one CPU bus cycle, then release all strobes.
    task automatic applyStimulus(input logic aw, input logic dw, input logic dr,
                                 input logic [7:0] din, input logic ob7);
        bus.cpu_addr_wr = aw;
        bus.cpu_data_wr = dw;
        bus.cpu_data_rd = dr;
        bus.cpu_din     = din;
        bus.open_bus_b7 = ob7;
        @(posedge clock);
        #1;
        bus.cpu_addr_wr = 1'b0;
        bus.cpu_data_wr = 1'b0;
        bus.cpu_data_rd = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [14:0] d);
        tbWr   = 1'b1;
        tbAddr = a;
        tbData = d;
        @(posedge clock);
        #1;
        tbWr = 1'b0;
    endtask

    // Bounded wait for the prefetch to finish.
    task automatic waitNotBusy(input string tag, input int limit);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < limit) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput(tag, {15'd0, bus.busy}, 16'h0000);
    endtask

    initial begin
        int wrenBefore;
        compareCount   = 0;
        mismatchCount  = 0;
        wrenCount      = 0;
        lastWrAddr     = 8'h00;
        lastWrData     = 15'h0000;
        tbWr           = 1'b0;
        tbAddr         = 8'h00;
        tbData         = 15'h0000;
        render_addr    = 8'h00;
        bus.cpu_addr_wr = 1'b0;
        bus.cpu_data_wr = 1'b0;
        bus.cpu_data_rd = 1'b0;
        bus.cpu_din     = 8'h00;
        bus.open_bus_b7 = 1'b0;
        reset           = 1'b1;

        preload(8'h00, 15'h1357);
        preload(8'h11, 15'h0234);
        preload(8'h20, 15'h2A55);
        preload(8'h50, 15'h3ABC);
        preload(8'h51, 15'h4D66);
        preload(8'hFF, 15'h7FFF);
        @(negedge clock);
        checkOutput("rst_dout", {8'h00, bus.cpu_dout}, 16'h0000);
        checkOutput("rst_busy", {15'd0, bus.busy}, 16'h0001);
        checkOutput("rst_wren", {15'd0, ram_wren_a}, 16'h0000);
        checkOutput("rst_addr", {8'h00, ram_addr_a}, 16'h0000);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Word 0 prefetch after reset: idle within RAM_LAT+2, buffer holds mem[0].
        idleCycles(3);
        checkOutput("post_rst_busy", {15'd0, bus.busy}, 16'h0000);
        idleCycles(1);
        checkOutput("no_wren_idle", wrenCount[15:0], 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("rd0_lo", {8'h00, bus.cpu_dout}, 16'h0057);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("rd0_hi", {8'h00, bus.cpu_dout}, 16'h0013);

        // Write pair at 0x10.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h1F, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h7C, 1'b0);
        idleCycles(1);
        checkOutput("wr_count", wrenCount[15:0], 16'h0001);
        checkOutput("wr_addr", {8'h00, lastWrAddr}, 16'h0010);
        checkOutput("wr_data", {1'b0, lastWrData}, 16'h7C1F);
        waitNotBusy("wr_settle", 10);
        checkOutput("wr_next_addr", {8'h00, ram_addr_a}, 16'h0011);
        checkOutput("wr_mem", {1'b0, mem[8'h10]}, 16'h7C1F);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("wr_flip_lo", {8'h00, bus.cpu_dout}, 16'h0034);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("wr_flip_hi", {8'h00, bus.cpu_dout}, 16'h0002);

        // Read pair at 0x20 with open bus bit 7 set.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h20, 1'b0);
        idleCycles(4);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        checkOutput("rd20_lo", {8'h00, bus.cpu_dout}, 16'h0055);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        @(negedge clock);
        checkOutput("rd20_hi", {8'h00, bus.cpu_dout}, 16'h00AA);
        checkOutput("rd20_reissue", {15'd0, bus.busy}, 16'h0001);
        checkOutput("rd20_addr", {8'h00, ram_addr_a}, 16'h0021);
        waitNotBusy("rd20_settle", 10);
        checkOutput("dout_hold", {8'h00, bus.cpu_dout}, 16'h00AA);

        // Write at 0xFF drops bit 7 and wraps the address.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h80, 1'b0);
        idleCycles(1);
        checkOutput("wrap_wr_addr", {8'h00, lastWrAddr}, 16'h00FF);
        checkOutput("wrap_wr_data", {1'b0, lastWrData}, 16'h0000);
        waitNotBusy("wrap_settle", 10);
        checkOutput("wrap_addr", {8'h00, ram_addr_a}, 16'h0000);
        checkOutput("wrap_mem", {1'b0, mem[8'hFF]}, 16'h0000);

        // $2121 and the second $2122 in the same cycle: address wins, no write.
        wrenBefore = wrenCount;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h40, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h50, 1'b0);
        idleCycles(1);
        checkOutput("coin_no_wr", 16'(wrenCount - wrenBefore), 16'h0000);
        waitNotBusy("coin_settle", 10);
        checkOutput("coin_addr", {8'h00, ram_addr_a}, 16'h0050);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("coin_lo", {8'h00, bus.cpu_dout}, 16'h00BC);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("coin_hi", {8'h00, bus.cpu_dout}, 16'h003A);

        // Shared flip: low-byte write then a read returns the high byte of 0x51.
        waitNotBusy("shared_settle", 10);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
        idleCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        checkOutput("shared_hi", {8'h00, bus.cpu_dout}, 16'h00CD);
        checkOutput("shared_addr", {8'h00, ram_addr_a}, 16'h0052);
        checkOutput("shared_no_wr", 16'(wrenCount - wrenBefore), 16'h0000);

        // Reset on the edge of a second $2122: write dropped, state cleared.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h30, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hAB, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hCD, 1'b0);
        @(negedge clock);
        checkOutput("mid_rst_wren", {15'd0, ram_wren_a}, 16'h0000);
        checkOutput("mid_rst_dout", {8'h00, bus.cpu_dout}, 16'h0000);
        checkOutput("mid_rst_busy", {15'd0, bus.busy}, 16'h0001);
        checkOutput("mid_rst_addr", {8'h00, ram_addr_a}, 16'h0000);
        @(posedge clock);
        #1;
        reset = 1'b0;
        waitNotBusy("mid_rst_settle", 10);
        checkOutput("mid_rst_no_wr", 16'(wrenCount - wrenBefore), 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("mid_rst_rd", {8'h00, bus.cpu_dout}, 16'h0057);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // Render sweep under continuous CPU writes.
        for (int i = 0; i < 256; i++) begin
            render_addr     = 8'(i);
            bus.cpu_data_wr = 1'b1;
            bus.cpu_din     = 8'(i * 7);
            @(negedge clock);
            checkOutput("rnd_data", {1'b0, render_data}, {1'b0, ram_q_b});
            checkOutput("rnd_addr", {8'h00, ram_addr_b}, 16'(i));
            checkOutput("rnd_wren", {15'd0, ram_wren_b}, 16'h0000);
            @(posedge clock);
            #1;
        end
        bus.cpu_data_wr = 1'b0;
        idleCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
